vector_sweep_checker: RTL and testbench
=======================================

// Module: vector_sweep_checker
// PURPOSE
//   Self-running exhaustive stimulus/check stage for small combinational gates (And4 and peers).
//   Drives all 2^N_IN input vectors into the DUT in ascending order.
//   Samples the DUT output after a settle window and compares it against a reference function.
//   Reports the mismatch count and a pass/fail flag. Sits directly upstream and downstream of the gate under test.
// PARAMETERS
//   N_IN         4  DUT input width; vectors 0 .. 2^N_IN-1
//   HOLD_CYCLES  1  settle cycles per vector before sampling; legal range >=1
//   FUNC         0  reference function: 0=AND-reduce, 1=OR-reduce, 2=XOR-reduce; other values = AND
// PORTS
//   clk             in   1          single clock; all state on the rising edge
//   rst_n           in   1          asynchronous, active-low reset
//   start           in   1          request a sweep; sampled only in IDLE
//   dut_out         in   1          DUT output under test
//   dut_in          out  N_IN       vector currently driven to the DUT; equals vec_idx
//   vec_idx         out  N_IN       index of the current vector
//   busy            out  1          high in SETTLE and SAMPLE
//   done            out  1          one-cycle pulse at sweep end
//   pass            out  1          err_cnt==0 at the last done; holds until the next start
//   err_cnt         out  N_IN+1     mismatch count; max 2^N_IN, so it never overflows
//   first_fail_vld  out  1          a mismatch has been logged (see CONFIGURATION)
//   first_fail_idx  out  N_IN       vec_idx of the first mismatch (see CONFIGURATION)
// BEHAVIOUR
//   Reset: every output is 0 and the FSM is in IDLE. rst_n low at any time, including mid-sweep,
//     aborts immediately. No done pulse is produced.
//   FSM states: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//   IDLE, start=1:
//     - clear vec_idx, err_cnt, pass and first_fail_*
//     - load settle_cnt = HOLD_CYCLES-1
//     - go to SETTLE
//   SETTLE: decrement settle_cnt each cycle. When settle_cnt==0, go to SAMPLE.
//     This gives exactly HOLD_CYCLES cycles in SETTLE.
//   SAMPLE: one cycle.
//     - exp = FUNC-reduce(dut_in); if dut_out != exp, err_cnt increments by 1
//     - if vec_idx == all-ones, go to DONE; vec_idx does not wrap
//     - otherwise vec_idx+1, reload settle_cnt, go to SETTLE
//   DONE: one cycle. done=1, pass=(err_cnt==0), then return to IDLE.
//   Latency: done is high in cycle 2^N_IN*(HOLD_CYCLES+1) counted after the edge that sampled start.
//     For N_IN=4, HOLD_CYCLES=1 that is cycle 32.
//   start is ignored outside IDLE. start held high re-arms a new sweep in the cycle after DONE.
//   dut_in changes only on the edge leaving SAMPLE. It is stable throughout SETTLE and SAMPLE.
//   The err_cnt update in SAMPLE of the last vector is visible in the DONE cycle and counts toward pass.
// CONFIGURATION
//   Macro: SWEEP_FIRST_FAIL_EN.
//   Defined: on the first mismatch of a sweep, first_fail_idx <= vec_idx and first_fail_vld <= 1.
//     Later mismatches do not overwrite them. Both clear on start and on reset.
//   Undefined: the capture logic is not compiled; first_fail_vld and first_fail_idx are constant 0.
// STRUCTURE
//   Package sweep_pkg:
//     - state encoding localparams S_IDLE, S_SETTLE, S_SAMPLE, S_DONE
//     - FUNC codes F_AND, F_OR, F_XOR
//   Sub-module sweep_ref_func: combinational, params N_IN and FUNC, in vec, out exp.
//   The top block holds the FSM, settle counter, vec_idx and err_cnt.
// TESTING (N_IN=4, HOLD_CYCLES=1 unless stated)
//   1 Ideal And4 as DUT, pulse start -> dut_in steps 0..15 every 2 cycles; done at cycle 32; err_cnt=0, pass=1.
//   2 DUT stuck-at-0 -> err_cnt=1, pass=0; with SWEEP_FIRST_FAIL_EN, first_fail_idx=15, vld=1.
//   3 DUT stuck-at-1 -> err_cnt=15, pass=0, first_fail_idx=0; without the macro, first_fail_* stay 0.
//   4 start pulsed again at vec_idx=5 -> ignored; sweep completes unchanged, single done pulse.
//   5 rst_n low for 1 cycle at vec_idx=7 -> all outputs 0 asynchronously, FSM in IDLE,
//     no done; a new start then sweeps correctly.
//   6 HOLD_CYCLES=3, FUNC=2, ideal XOR4 DUT -> each vector held 4 cycles; done at cycle 64; err_cnt=0, pass=1.

Source files
------------

// File: rtl/sweep_pkg.sv
// sweep_pkg: shared FSM state encoding and reference-function codes for vector_sweep_checker
package sweep_pkg;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;
   localparam int F_AND = 0;
   localparam int F_OR  = 1;
   localparam int F_XOR = 2;
endpackage

// File: rtl/sweep_ref_func.sv
// sweep_ref_func: golden reduction of the driven vector; unknown FUNC codes fall back to AND
module sweep_ref_func
   import sweep_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int FUNC = F_AND
) (
   input  logic [N_IN-1:0] vec,
   output logic            exp
);
   assign exp = (FUNC == F_OR) ? |vec : (FUNC == F_XOR) ? ^vec : &vec;
endmodule

// File: rtl/vector_sweep_checker.sv
// vector_sweep_checker: exhaustive sweep of all 2^N_IN vectors into a small gate, checked against sweep_ref_func
// Optional first-mismatch capture is compiled in when SWEEP_FIRST_FAIL_EN is defined.
module vector_sweep_checker
   import sweep_pkg::*;
#(
   parameter int N_IN        = 4,
   parameter int HOLD_CYCLES = 1,
   parameter int FUNC        = F_AND
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] dut_in,
   output logic [N_IN-1:0] vec_idx,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic            first_fail_vld,
   output logic [N_IN-1:0] first_fail_idx
);
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);
   state_t          state_q;
   logic [CW-1:0]   settle_q;
   logic [N_IN-1:0] vec_q;
   logic [N_IN:0]   err_q;
   logic [N_IN:0]   err_d;
   logic            pass_q;
   logic            exp;
   logic            miss;
   sweep_ref_func #(.N_IN(N_IN), .FUNC(FUNC)) u_ref (.vec(vec_q), .exp(exp));
   assign miss  = (state_q == S_SAMPLE) && (dut_out != exp);
   assign err_d = err_q + {{N_IN{1'b0}}, miss};
   // pass is taken from err_d so the last vector's mismatch already counts in the DONE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         settle_q <= '0;
         vec_q    <= '0;
         err_q    <= '0;
         pass_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               state_q  <= S_SETTLE;
               settle_q <= RELOAD;
               vec_q    <= '0;
               err_q    <= '0;
               pass_q   <= 1'b0;
            end
            S_SETTLE: if (settle_q == '0) state_q <= S_SAMPLE;
                      else settle_q <= settle_q - CW'(1);
            S_SAMPLE: begin
               err_q <= err_d;
               if (&vec_q) begin
                  state_q <= S_DONE;
                  pass_q  <= (err_d == '0);
               end else begin
                  state_q  <= S_SETTLE;
                  settle_q <= RELOAD;
                  vec_q    <= vec_q + N_IN'(1);
               end
            end
            S_DONE: state_q <= S_IDLE;
         endcase
      end
   end
   assign dut_in  = vec_q;
   assign vec_idx = vec_q;
   assign busy    = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign done    = (state_q == S_DONE);
   assign pass    = pass_q;
   assign err_cnt = err_q;
`ifdef SWEEP_FIRST_FAIL_EN
   logic            ffv_q;
   logic [N_IN-1:0] ffi_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ffv_q <= 1'b0;
         ffi_q <= '0;
      end else if (state_q == S_IDLE && start) begin
         ffv_q <= 1'b0;
         ffi_q <= '0;
      end else if (miss && !ffv_q) begin
         ffv_q <= 1'b1;
         ffi_q <= vec_q;
      end
   end
   assign first_fail_vld = ffv_q;
   assign first_fail_idx = ffi_q;
`else
   assign first_fail_vld = 1'b0;
   assign first_fail_idx = '0;
`endif
endmodule

// File: tb/tb_vector_sweep_checker.sv
// tb_vector_sweep_checker: table of sweep scenarios against two checker builds (AND/H=1, XOR/H=3)
module tb_vector_sweep_checker;
`ifdef SWEEP_FIRST_FAIL_EN
   localparam bit FF_EN = 1'b1;
`else
   localparam bit FF_EN = 1'b0;
`endif
   typedef struct {
      bit sel;
      int mode;
      int bad;
      int pulse_at;
      int err;
      bit pass;
      int ffidx;
   } vec_t;
   typedef struct {
      int err;
      bit pass;
      bit vld;
      int idx;
      int lat;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n, start, sel;
   int   mode, bad;
   int   n_vec = 0;
   int   n_miss = 0;
   exp_t sbq[$];
   vec_t tbl[9];
   logic [3:0] dut_in_a, vec_a, ffi_a, dut_in_b, vec_b, ffi_b;
   logic [4:0] err_a, err_b;
   logic busy_a, done_a, pass_a, ffv_a, busy_b, done_b, pass_b, ffv_b;
   logic dut_out_a, dut_out_b, start_a, start_b;
   always #5 clk = ~clk;
   function automatic logic model(input logic [3:0] v, input bit x, input int m, input int b);
      logic r;
      r = x ? ^v : &v;
      return (m == 1) ? 1'b0 : (m == 2) ? 1'b1 : (m == 3) ? (r ^ (v == 4'(b))) : r;
   endfunction
   assign dut_out_a = model(dut_in_a, 1'b0, mode, bad);
   assign dut_out_b = model(dut_in_b, 1'b1, mode, bad);
   assign start_a = start & ~sel;
   assign start_b = start & sel;
   vector_sweep_checker #(.N_IN(4), .HOLD_CYCLES(1), .FUNC(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a), .dut_in(dut_in_a),
      .vec_idx(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
      .first_fail_vld(ffv_a), .first_fail_idx(ffi_a));
   vector_sweep_checker #(.N_IN(4), .HOLD_CYCLES(3), .FUNC(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b), .dut_in(dut_in_b),
      .vec_idx(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
      .first_fail_vld(ffv_b), .first_fail_idx(ffi_b));
   wire [3:0] o_in   = sel ? dut_in_b : dut_in_a;
   wire [3:0] o_vec  = sel ? vec_b : vec_a;
   wire [3:0] o_ffi  = sel ? ffi_b : ffi_a;
   wire [4:0] o_err  = sel ? err_b : err_a;
   wire       o_busy = sel ? busy_b : busy_a;
   wire       o_done = sel ? done_b : done_a;
   wire       o_pass = sel ? pass_b : pass_a;
   wire       o_ffv  = sel ? ffv_b : ffv_a;
   task automatic chk(input string name, input int act, input int want);
      n_vec++;
      if (act != want) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask
   task automatic run(input vec_t v);
      exp_t e;
      int   hold, total, n;
      bit   pulsed;
      hold = v.sel ? 3 : 1;
      total = 16 * (hold + 1);
      sel = v.sel;
      mode = v.mode;
      bad = v.bad;
      e.err = v.err;
      e.pass = v.pass;
      e.vld = FF_EN && (v.err > 0);
      e.idx = e.vld ? v.ffidx : 0;
      e.lat = total;
      @(negedge clk);
      start = 1'b1;
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      pulsed = 1'b0;
      while (!o_done && n < total + 20) begin
         chk("dut_in", int'(o_in), (n / (hold + 1) > 15) ? 15 : n / (hold + 1));
         chk("vec_idx", int'(o_vec), int'(o_in));
         chk("busy", int'(o_busy), 1);
         start = (v.pulse_at >= 0) && !pulsed && (int'(o_vec) == v.pulse_at);
         if (start) pulsed = 1'b1;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      e = sbq.pop_front();
      if (!o_done) begin
         chk("done_timeout", n, e.lat);
      end else begin
         chk("latency", n, e.lat);
         chk("err_cnt", int'(o_err), e.err);
         chk("pass", int'(o_pass), int'(e.pass));
         chk("ff_vld", int'(o_ffv), int'(e.vld));
         chk("ff_idx", int'(o_ffi), e.idx);
         chk("last_vec", int'(o_in), 15);
         @(negedge clk);
         chk("done_pulse", int'(o_done), 0);
         chk("idle_busy", int'(o_busy), 0);
         chk("pass_hold", int'(o_pass), int'(e.pass));
         chk("err_hold", int'(o_err), e.err);
      end
   endtask
   initial begin
      int n, d;
      tbl[0] = '{0, 0, 0, -1, 0, 1, 0};
      tbl[1] = '{0, 1, 0, -1, 1, 0, 15};
      tbl[2] = '{0, 2, 0, -1, 15, 0, 0};
      tbl[3] = '{0, 3, 6, -1, 1, 0, 6};
      tbl[4] = '{0, 3, 0, -1, 1, 0, 0};
      tbl[5] = '{0, 0, 0, 5, 0, 1, 0};
      tbl[6] = '{1, 0, 0, -1, 0, 1, 0};
      tbl[7] = '{1, 3, 9, -1, 1, 0, 9};
      tbl[8] = '{1, 2, 0, -1, 8, 0, 0};
      rst_n = 1'b0;
      start = 1'b0;
      sel = 1'b0;
      mode = 0;
      bad = 0;
      repeat (2) @(negedge clk);
      chk("rst_a", int'({dut_in_a, vec_a, busy_a, done_a, pass_a, err_a, ffv_a, ffi_a}), 0);
      chk("rst_b", int'({dut_in_b, vec_b, busy_b, done_b, pass_b, err_b, ffv_b, ffi_b}), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) run(tbl[i]);
      sel = 1'b0;
      mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (dut_in_a != 4'd7 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_vec7", int'(dut_in_a), 7);
      chk("err_before_rst", int'(err_a), 7);
      rst_n = 1'b0;
      #1;
      chk("async_rst_vec", int'({dut_in_a, vec_a}), 0);
      chk("async_rst_flags", int'({busy_a, done_a, pass_a}), 0);
      chk("async_rst_err", int'(err_a), 0);
      chk("async_rst_ff", int'({ffv_a, ffi_a}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      d = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         d += int'(done_a) + int'(busy_a);
      end
      chk("no_done_after_rst", d, 0);
      run(tbl[0]);
      mode = 0;
      start = 1'b1;
      n = 0;
      while (!done_a && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rearm_done", int'(done_a), 1);
      @(negedge clk);
      chk("rearm_idle", int'(busy_a), 0);
      @(negedge clk);
      chk("rearm_busy", int'(busy_a), 1);
      chk("rearm_clear", int'({pass_a, err_a, vec_a}), 0);
      start = 1'b0;
      n = 0;
      while (!done_a && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("rearm_pass", int'(pass_a), 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
